// File: rtl/ex2_cmd_deser.sv
// rtl/ex2_cmd_deser.sv - bit-serial command frame loader with one-word output buffer
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   sin_valid/sin_data/sin_sof/sin_ready
//                     serial input, MSB first; sin_sof marks the first bit of a frame
//   word_data/word_valid/word_ready
//                     parallel output register with valid/ready handshake
//   parity_err        one-cycle pulse: frame dropped on bad even parity
//   sync_err          one-cycle pulse: partial frame aborted by a new sof
//   frame_cnt         committed word count, wraps at 256
module ex2_cmd_deser #(
    parameter int WIDTH     = 16,
    parameter int PARITY_EN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sin_valid,
    input  logic             sin_data,
    input  logic             sin_sof,
    output logic             sin_ready,
    output logic [WIDTH-1:0] word_data,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             parity_err,
    output logic             sync_err,
    output logic [7:0]       frame_cnt
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2,
        FULL  = 2'd3
    } state_t;

    state_t           state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic [WIDTH-1:0] wdata_n;
    logic             wvalid_n;
    logic [7:0]       fcnt_n;
    logic             perr_n, serr_n;
    // Low through reset and for nothing else; keeps sin_ready low until the
    // first edge after reset release.
    logic             live;

    logic             accept;
    logic             drain;
    logic             commit;
    logic [WIDTH-1:0] commit_word;
    logic [WIDTH-1:0] sof_word;
    logic [WIDTH-1:0] shifted;

    assign sin_ready = live && (state != FULL);
    assign accept    = sin_valid && sin_ready;
    assign drain     = word_valid && word_ready;
    assign sof_word  = {{(WIDTH-1){1'b0}}, sin_data};
    assign shifted   = {shreg[WIDTH-2:0], sin_data};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            shreg      <= '0;
            word_data  <= '0;
            word_valid <= 1'b0;
            frame_cnt  <= 8'd0;
            parity_err <= 1'b0;
            sync_err   <= 1'b0;
            live       <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            shreg      <= shreg_n;
            word_data  <= wdata_n;
            word_valid <= wvalid_n;
            frame_cnt  <= fcnt_n;
            parity_err <= perr_n;
            sync_err   <= serr_n;
            live       <= 1'b1;
        end
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        shreg_n     = shreg;
        wdata_n     = word_data;
        wvalid_n    = word_valid;
        fcnt_n      = frame_cnt;
        perr_n      = 1'b0;
        serr_n      = 1'b0;
        commit      = 1'b0;
        commit_word = shreg;

        if (drain) begin
            wvalid_n = 1'b0;
        end

        case (state)
            IDLE: begin
                if (accept && sin_sof) begin
                    shreg_n = sof_word;
                    cnt_n   = CW'(1);
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                if (accept) begin
                    if (sin_sof) begin
                        // Abort and restart, including on the final data bit.
                        serr_n  = 1'b1;
                        shreg_n = sof_word;
                        cnt_n   = CW'(1);
                    end else begin
                        shreg_n = shifted;
                        cnt_n   = cnt + CW'(1);
                        if (cnt == LAST_IDX) begin
                            if (PARITY_EN != 0) begin
                                state_n = PAR;
                            end else begin
                                commit      = 1'b1;
                                commit_word = shifted;
                            end
                        end
                    end
                end
            end
            PAR: begin
                if (accept) begin
                    if (sin_sof) begin
                        serr_n  = 1'b1;
                        shreg_n = sof_word;
                        cnt_n   = CW'(1);
                        state_n = SHIFT;
                    end else if ((^shreg ^ sin_data) == 1'b0) begin
                        commit = 1'b1;
                    end else begin
                        perr_n  = 1'b1;
                        cnt_n   = '0;
                        state_n = IDLE;
                    end
                end
            end
            FULL: begin
                // word_valid is always set here; the held word follows the
                // departing one on the same edge.
                if (drain) begin
                    wdata_n  = shreg;
                    wvalid_n = 1'b1;
                    fcnt_n   = frame_cnt + 8'd1;
                    cnt_n    = '0;
                    state_n  = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase

        if (commit) begin
            shreg_n = commit_word;
            cnt_n   = '0;
            if (!word_valid || word_ready) begin
                wdata_n  = commit_word;
                wvalid_n = 1'b1;
                fcnt_n   = frame_cnt + 8'd1;
                state_n  = IDLE;
            end else begin
                state_n = FULL;
            end
        end
    end

endmodule

// File: tb/tb_ex2_cmd_deser.sv
// tb/tb_ex2_cmd_deser.sv - scoreboard bench for ex2_cmd_deser (WIDTH=16, PARITY_EN=1)
module tb_ex2_cmd_deser;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sin_valid = 1'b0;
    logic        sin_data = 1'b0;
    logic        sin_sof = 1'b0;
    logic        sin_ready;
    logic [15:0] word_data;
    logic        word_valid;
    logic        word_ready = 1'b0;
    logic        parity_err;
    logic        sync_err;
    logic [7:0]  frame_cnt;

    int total = 0;
    int bad = 0;
    int perr_cycles = 0;
    int serr_cycles = 0;
    logic [15:0] exp_q[$];

    ex2_cmd_deser #(.WIDTH(16), .PARITY_EN(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sin_valid  (sin_valid),
        .sin_data   (sin_data),
        .sin_sof    (sin_sof),
        .sin_ready  (sin_ready),
        .word_data  (word_data),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .parity_err (parity_err),
        .sync_err   (sync_err),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: a handshake seen at the negedge completes on the next posedge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (parity_err) perr_cycles++;
            if (sync_err) serr_cycles++;
            if (word_valid && word_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_word: got %04h expected none", word_data);
                end else begin
                    logic [15:0] e;
                    e = exp_q.pop_front();
                    if (word_data !== e) begin
                        bad++;
                        $display("FAIL word_data: got %04h expected %04h", word_data, e);
                    end
                end
            end
        end
    end

    // Returns at posedge+1 after the edge that accepted the bit.
    task automatic send_bit(input logic d, input logic sof);
        int n;
        sin_valid = 1'b1;
        sin_data  = d;
        sin_sof   = sof;
        n = 0;
        while (!sin_ready && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 500) check("sin_ready_timeout", 32'(sin_ready), 32'd1);
        @(posedge clk);
        #1;
        sin_valid = 1'b0;
        sin_sof   = 1'b0;
    endtask

    task automatic send_data(input logic [15:0] w);
        for (int i = 15; i >= 0; i--) send_bit(w[i], i == 15);
    endtask

    task automatic send_frame(input logic [15:0] w, input logic par);
        send_data(w);
        send_bit(par, 1'b0);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int p0, s0, n;
        logic [7:0] f0;
        logic [15:0] w;

        // Reset state
        #12;
        check("rst_sin_ready", 32'(sin_ready), 32'd0);
        check("rst_word_valid", 32'(word_valid), 32'd0);
        check("rst_word_data", 32'(word_data), 32'd0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        check("rst_errs", {30'd0, parity_err, sync_err}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("ready_before_edge", 32'(sin_ready), 32'd0);
        cycle();
        check("ready_after_edge", 32'(sin_ready), 32'd1);

        // Single good frame
        word_ready = 1'b1;
        p0 = perr_cycles; s0 = serr_cycles;
        exp_q.push_back(16'hA5C3);
        send_data(16'hA5C3);
        check("valid_before_parity", 32'(word_valid), 32'd0);
        send_bit(1'b0, 1'b0);
        check("valid_after_parity", 32'(word_valid), 32'd1);
        check("frame_cnt_1", 32'(frame_cnt), 32'd1);
        cycle();
        check("valid_one_cycle", 32'(word_valid), 32'd0);
        check("no_err_pulses", 32'((perr_cycles - p0) + (serr_cycles - s0)), 32'd0);

        // Bad parity
        p0 = perr_cycles;
        send_frame(16'h0001, 1'b0);
        check("perr_pulse", 32'(parity_err), 32'd1);
        check("perr_no_valid", 32'(word_valid), 32'd0);
        cycle();
        check("perr_clear", 32'(parity_err), 32'd0);
        check("perr_cycles", 32'(perr_cycles - p0), 32'd1);
        check("perr_frame_cnt", 32'(frame_cnt), 32'd1);

        // Back-pressure
        word_ready = 1'b0;
        exp_q.push_back(16'h1111);
        exp_q.push_back(16'h2222);
        send_frame(16'h1111, 1'b0);
        send_frame(16'h2222, 1'b0);
        check("bp_sin_ready_low", 32'(sin_ready), 32'd0);
        check("bp_word_data_old", 32'(word_data), 32'h1111);
        cycle();
        check("bp_still_stalled", 32'(sin_ready), 32'd0);
        word_ready = 1'b1;
        cycle();
        word_ready = 1'b0;
        check("bp_word_data_new", 32'(word_data), 32'h2222);
        check("bp_word_valid", 32'(word_valid), 32'd1);
        check("bp_sin_ready_back", 32'(sin_ready), 32'd1);
        check("bp_frame_cnt", 32'(frame_cnt), 32'd3);
        word_ready = 1'b1;
        cycle();

        // Resync after 7 data bits (sof + 7 bits), then on the final data bit
        s0 = serr_cycles;
        exp_q.push_back(16'hBEEF);
        send_bit(1'b1, 1'b1);
        for (int i = 0; i < 7; i++) send_bit(i[0], 1'b0);
        send_frame(16'hBEEF, 1'b1);
        cycle();
        check("resync_serr_cycles", 32'(serr_cycles - s0), 32'd1);
        check("resync_frame_cnt", 32'(frame_cnt), 32'd4);
        s0 = serr_cycles;
        exp_q.push_back(16'h8001);
        w = 16'hFFFF;
        for (int i = 15; i >= 1; i--) send_bit(w[i], i == 15);
        send_frame(16'h8001, 1'b0);
        cycle();
        check("lastbit_serr_cycles", 32'(serr_cycles - s0), 32'd1);
        check("lastbit_frame_cnt", 32'(frame_cnt), 32'd5);

        // 256 back-to-back frames: counter wraps to its start value
        f0 = frame_cnt;
        for (int k = 0; k < 256; k++) begin
            w = 16'(k * 16'h0101) ^ 16'h3C5A;
            exp_q.push_back(w);
            send_frame(w, ^w);
        end
        cycle();
        check("wrap_frame_cnt", 32'(frame_cnt), 32'(f0));
        check("wrap_queue_empty", 32'(exp_q.size()), 32'd0);

        // Reset mid-frame with a word held in the output register
        word_ready = 1'b0;
        exp_q.push_back(16'h1234);
        send_frame(16'h1234, 1'b1);
        send_data(16'h5555);
        check("pre_rst_valid", 32'(word_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_sin_ready", 32'(sin_ready), 32'd0);
        check("mid_rst_word_valid", 32'(word_valid), 32'd0);
        check("mid_rst_word_data", 32'(word_data), 32'd0);
        check("mid_rst_frame_cnt", 32'(frame_cnt), 32'd0);
        exp_q.delete();
        cycle();
        rst_n = 1'b1;
        cycle();
        word_ready = 1'b1;
        exp_q.push_back(16'h5A5A);
        send_frame(16'h5A5A, 1'b0);
        check("post_rst_valid", 32'(word_valid), 32'd1);
        check("post_rst_frame_cnt", 32'(frame_cnt), 32'd1);

        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            cycle();
            n++;
        end
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
